// File: rtl/ts_pkg.sv
// Shared definitions for the track-stub processing chain.
package ts_pkg;

  localparam int unsigned STUB_CNT_BITS = 8;
  localparam int unsigned TS_NCH        = 4;

  typedef logic [STUB_CNT_BITS-1:0] stub_cnt_t;

  typedef enum logic [0:0] {StIdle, StRun} seq_state_e;

endpackage

// File: rtl/ts_stub_seq_if.sv
// Load and token handshake bundle of the multi-channel stub sequencer.
interface ts_stub_seq_if
  import ts_pkg::*;
#(
  parameter int unsigned NCH      = TS_NCH,
  parameter int unsigned CNT_BITS = STUB_CNT_BITS,
  parameter int unsigned CH_BITS  = $clog2(NCH)
);

  logic                    ld_en;
  logic [NCH*CNT_BITS-1:0] init;
  logic                    ld_ready;
  logic                    ld_err;
  logic                    out_valid;
  logic                    out_ready;
  logic [CH_BITS-1:0]      out_ch;
  logic [CNT_BITS-1:0]     out_idx;
  logic                    out_last;
  logic                    done;
  logic                    busy;

  modport master (
    output ld_en, init, out_ready,
    input  ld_ready, ld_err, out_valid, out_ch, out_idx, out_last, done, busy
  );

  modport slave (
    input  ld_en, init, out_ready,
    output ld_ready, ld_err, out_valid, out_ch, out_idx, out_last, done, busy
  );

endinterface

// File: rtl/ts_rr_arb.sv
// Round-robin priority picker: first requesting channel at or after ptr, cyclic.
module ts_rr_arb #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CH_BITS = $clog2(NCH)
) (
  input  logic [NCH-1:0]     req,
  input  logic [CH_BITS-1:0] ptr,
  output logic [CH_BITS-1:0] grant,
  output logic               any
);

  always_comb begin
    int unsigned c;
    grant = '0;
    any   = 1'b0;
    c     = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      c = (32'(ptr) + i) % NCH;
      if (!any && req[c[CH_BITS-1:0]]) begin
        any   = 1'b1;
        grant = c[CH_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/ts_stub_seq.sv
// Multi-channel stub sequencer: double-buffered per-channel counts drained one
// token per cycle in round-robin channel order.
module ts_stub_seq
  import ts_pkg::*;
#(
  parameter int unsigned NCH      = TS_NCH,
  parameter int unsigned CNT_BITS = STUB_CNT_BITS,
  parameter int unsigned CH_BITS  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  ts_stub_seq_if.slave  bus
);

  typedef logic [CNT_BITS-1:0] cnt_t;

  seq_state_e         state_q, state_d;
  cnt_t               pend_q [NCH];
  cnt_t               pend_d [NCH];
  cnt_t               cnt_q  [NCH];
  cnt_t               cnt_d  [NCH];
  logic               pend_full_q, pend_full_d;
  logic [CH_BITS-1:0] ptr_q, ptr_d;
  logic               ld_err_q, ld_err_d;
  logic               done_q, done_d;

  logic [NCH-1:0]     req;
  logic [NCH-1:0]     grant_oh;
  logic [CH_BITS-1:0] grant;
  logic               any;
  cnt_t               cur;
  logic               last;
  logic               pend_zero;
  logic               run;

  always_comb begin
    pend_zero = 1'b1;
    for (int k = 0; k < int'(NCH); k++) begin
      req[k] = (cnt_q[k] != '0);
      if (pend_q[k] != '0) pend_zero = 1'b0;
    end
  end

  ts_rr_arb #(
    .NCH     (NCH),
    .CH_BITS (CH_BITS)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant),
    .any   (any)
  );

  assign run      = (state_q == StRun);
  assign cur      = cnt_q[grant];
  assign grant_oh = NCH'(1) << grant;
  // Last of the crossing: one stub left on the granted channel, nothing elsewhere.
  assign last     = any && (cur == cnt_t'(1)) && (req == grant_oh);

  // Outputs depend on registered state only; idle values forced to zero.
  assign bus.out_valid = run;
  assign bus.out_ch    = run ? grant : '0;
  assign bus.out_idx   = run ? cur - cnt_t'(1) : '0;
  assign bus.out_last  = run && last;
  assign bus.ld_ready  = !pend_full_q;
  assign bus.ld_err    = ld_err_q;
  assign bus.done      = done_q;
  assign bus.busy      = run || pend_full_q;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    ld_err_d    = ld_err_q;
    done_d      = 1'b0;

    if (bus.ld_en) begin
      if (!pend_full_q) begin
        for (int k = 0; k < int'(NCH); k++) begin
          pend_d[k] = bus.init[k*CNT_BITS +: CNT_BITS];
        end
        pend_full_d = 1'b1;
      end else begin
        ld_err_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (pend_full_q) begin
          cnt_d       = pend_q;
          pend_full_d = 1'b0;
          if (pend_zero) done_d = 1'b1;
          else           state_d = StRun;
        end
      end
      StRun: begin
        if (bus.out_ready) begin
          cnt_d[grant] = cur - cnt_t'(1);
          ptr_d        = (grant == CH_BITS'(NCH - 1)) ? '0 : grant + CH_BITS'(1);
          if (last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pend_q      <= '{default: '0};
      cnt_q       <= '{default: '0};
      pend_full_q <= 1'b0;
      ptr_q       <= '0;
      ld_err_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      ptr_q       <= ptr_d;
      ld_err_q    <= ld_err_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_ts_stub_seq.sv
// Randomised self-checking bench for ts_stub_seq against a token-list reference model.
module tb_ts_stub_seq;
  import ts_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = STUB_CNT_BITS;
  localparam int CHB = 2;

  typedef int cnt_arr_t [NCH];
  typedef struct {
    int ch;
    int idx;
    bit last;
  } tok_t;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;
  int   m_ptr;
  tok_t exp_q [$];

  ts_stub_seq_if #(.NCH(NCH), .CNT_BITS(CW)) bus ();

  ts_stub_seq #(.NCH(NCH), .CNT_BITS(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH*CW-1:0] pack(input cnt_arr_t c);
    logic [NCH*CW-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) v[k*CW +: CW] = CW'(c[k]);
    return v;
  endfunction

  // Expected token order for one crossing: repeatedly pick the first nonzero
  // channel at or after the pointer, decrement it, move the pointer past it.
  function automatic void model_push(input cnt_arr_t c);
    int r [NCH];
    int left;
    int g;
    left = 0;
    for (int k = 0; k < NCH; k++) begin
      r[k] = c[k];
      left += c[k];
    end
    while (left > 0) begin
      g = -1;
      for (int i = 0; i < NCH; i++) begin
        if (g < 0 && r[(m_ptr + i) % NCH] > 0) g = (m_ptr + i) % NCH;
      end
      r[g]--;
      left--;
      exp_q.push_back('{ch: g, idx: r[g], last: (left == 0)});
      m_ptr = (g + 1) % NCH;
    end
  endfunction

  task automatic load(input cnt_arr_t c);
    int w;
    w = 0;
    while (bus.ld_ready !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    if (w == 100) begin
      nvec++;
      nerr++;
      $display("FAIL load_wait: ld_ready=%b, required 1 within 100 cycles", bus.ld_ready);
    end
    bus.init  = pack(c);
    bus.ld_en = 1'b1;
    model_push(c);
    step();
    bus.ld_en = 1'b0;
  endtask

  // mode 0: always ready, 1: ready on even cycles, 2: random ready
  task automatic drain(input int mode, input int n_cross, input int budget);
    int   dones;
    int   cyc;
    bit   exp_gap;
    bit   r;
    tok_t e;
    dones   = 0;
    cyc     = 0;
    exp_gap = 1'b0;
    while ((exp_q.size() != 0 || dones < n_cross) && cyc < budget) begin
      if (bus.done === 1'b1) dones++;
      if (exp_gap) begin
        nvec++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
          nerr++;
          $display("FAIL last_done: done=%b out_valid=%b, required done=1 out_valid=0",
                   bus.done, bus.out_valid);
        end
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      exp_gap = 1'b0;
      if (bus.out_valid === 1'b1) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL spurious_valid: out_valid=1 ch=%0d idx=%0d, required no token",
                   bus.out_ch, bus.out_idx);
        end else begin
          e = exp_q[0];
          if ({bus.out_ch, bus.out_idx, bus.out_last} !== {CHB'(e.ch), CW'(e.idx), e.last}) begin
            nerr++;
            $display("FAIL token: ch=%0d idx=%0d last=%b, required ch=%0d idx=%0d last=%b",
                     bus.out_ch, bus.out_idx, bus.out_last, e.ch, e.idx, e.last);
          end
          if (r) begin
            exp_gap = e.last;
            void'(exp_q.pop_front());
          end
        end
      end
      step();
      cyc++;
    end
    nvec++;
    if (exp_q.size() != 0 || dones != n_cross) begin
      nerr++;
      $display("FAIL drain_end: %0d tokens left, %0d done pulses, required 0 left, %0d pulses",
               exp_q.size(), dones, n_cross);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    nvec++;
    if ({bus.ld_ready, bus.ld_err, bus.out_valid, bus.out_ch, bus.out_idx, bus.out_last,
         bus.done, bus.busy} !== {1'b1, 1'b0, 1'b0, CHB'(0), CW'(0), 1'b0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_outputs: rdy=%b err=%b vld=%b ch=%0d idx=%0d last=%b done=%b busy=%b, required 1 0 0 0 0 0 0 0",
               bus.ld_ready, bus.ld_err, bus.out_valid, bus.out_ch, bus.out_idx,
               bus.out_last, bus.done, bus.busy);
    end
    rst = 1'b0;
    m_ptr = 0;
    exp_q.delete();
    step();
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    load('{2, 0, 1, 3});
    nvec++;
    if ({bus.out_valid, bus.busy, bus.ld_ready} !== 3'b010) begin
      nerr++;
      $display("FAIL load_latency: vld=%b busy=%b rdy=%b, required 0 1 0",
               bus.out_valid, bus.busy, bus.ld_ready);
    end
    step();
    nvec++;
    if ({bus.out_valid, bus.ld_ready} !== 2'b11) begin
      nerr++;
      $display("FAIL first_token: vld=%b rdy=%b, required 1 1", bus.out_valid, bus.ld_ready);
    end
    drain(0, 1, 50);
  endtask

  task automatic test_stall();
    load('{2, 0, 1, 3});
    drain(1, 1, 60);
  endtask

  task automatic test_zero();
    bus.out_ready = 1'b1;
    load('{0, 0, 0, 0});
    nvec++;
    if (bus.done !== 1'b0) begin
      nerr++;
      $display("FAIL zero_early: done=%b, required 0", bus.done);
    end
    step();
    nvec++;
    if ({bus.done, bus.out_valid} !== 2'b10) begin
      nerr++;
      $display("FAIL zero_done: done=%b vld=%b, required 1 0", bus.done, bus.out_valid);
    end
    step();
    nvec++;
    if ({bus.done, bus.out_valid, bus.busy} !== 3'b000) begin
      nerr++;
      $display("FAIL zero_after: done=%b vld=%b busy=%b, required 0 0 0",
               bus.done, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_overlap();
    bus.out_ready = 1'b0;
    load('{1, 1, 0, 0});
    step();
    load('{0, 0, 0, 2});
    nvec++;
    if ({bus.ld_ready, bus.busy, bus.out_valid} !== 3'b011) begin
      nerr++;
      $display("FAIL overlap_pending: rdy=%b busy=%b vld=%b, required 0 1 1",
               bus.ld_ready, bus.busy, bus.out_valid);
    end
    drain(0, 2, 60);
  endtask

  task automatic test_err();
    nvec++;
    if (bus.ld_err !== 1'b0) begin
      nerr++;
      $display("FAIL err_pre: ld_err=%b, required 0", bus.ld_err);
    end
    bus.out_ready = 1'b0;
    load('{0, 2, 1, 0});
    step();
    load('{3, 0, 0, 1});
    // pending bank is full: this load must be discarded
    bus.init  = pack('{1, 1, 1, 1});
    bus.ld_en = 1'b1;
    step();
    bus.ld_en = 1'b0;
    nvec++;
    if (bus.ld_err !== 1'b1) begin
      nerr++;
      $display("FAIL err_set: ld_err=%b, required 1", bus.ld_err);
    end
    drain(1, 2, 80);
    nvec++;
    if (bus.ld_err !== 1'b1) begin
      nerr++;
      $display("FAIL err_sticky: ld_err=%b, required 1", bus.ld_err);
    end
  endtask

  task automatic test_random();
    cnt_arr_t c;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < NCH; k++) c[k] = (it == 5) ? 0 : int'($urandom_range(0, 3));
      load(c);
      drain(2, 1, 200);
    end
  endtask

  task automatic test_rst_mid();
    bus.out_ready = 1'b1;
    load('{3, 3, 3, 3});
    step();
    step();
    load('{1, 2, 1, 2});
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if ({bus.out_valid, bus.busy, bus.ld_ready, bus.done} !== 4'b0010) begin
      nerr++;
      $display("FAIL rst_mid: vld=%b busy=%b rdy=%b done=%b, required 0 0 1 0",
               bus.out_valid, bus.busy, bus.ld_ready, bus.done);
    end
    step();
    rst = 1'b0;
    m_ptr = 0;
    exp_q.delete();
    step();
    nvec++;
    if ({bus.out_valid, bus.busy, bus.done, bus.ld_err} !== 4'b0000) begin
      nerr++;
      $display("FAIL rst_after: vld=%b busy=%b done=%b err=%b, required 0 0 0 0",
               bus.out_valid, bus.busy, bus.done, bus.ld_err);
    end
    test_basic();
  endtask

  initial begin
    clk           = 1'b0;
    rst           = 1'b1;
    nvec          = 0;
    nerr          = 0;
    m_ptr         = 0;
    bus.ld_en     = 1'b0;
    bus.init      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_overlap();
    test_err();
    test_random();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ts_stub_seq.md
# ts_stub_seq

Parametrised multi-channel stub sequencer, successor of the single-channel stub down-counter in the track-stub (TS) processing chain. Holds per-channel stub counts for one bunch crossing, issues one stub token per cycle across NCH channels in round-robin order, and double-buffers the next crossing's counts so loading overlaps draining. Sits between the per-crossing stub-count source and the fast-clock stub-fetch/processing logic.

## Interface
Parameters:
- NCH, 4: number of stub channels (≥2).
- CNT_BITS, `STUB_CNT_BITS`: width of each per-channel count.
- CH_BITS, $clog2(NCH): width of channel index.

Ports:
- clk  in  1  fast processing clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_en  in  1  load request; accepted only when ld_ready=1.
- init  in  NCH*CNT_BITS  per-channel stub counts; channel k at [k*CNT_BITS +: CNT_BITS].
- ld_ready  out  1  pending bank empty; load accepted this cycle.
- ld_err  out  1  sticky: ld_en seen while ld_ready=0; cleared only by rst.
- out_valid  out  1  stub token available.
- out_ready  in  1  downstream accepts token.
- out_ch  out  CH_BITS  channel of current token.
- out_idx  out  CNT_BITS  stub index within channel (= remaining count − 1).
- out_last  out  1  current token is last of the crossing.
- done  out  1  one-cycle pulse: crossing fully issued.
- busy  out  1  active bank in RUN or pending bank full.

## Operation
- Two banks: pending (NCH counts + pending_full flag) and active (NCH counters + state).
- Load: ld_en & ld_ready → pending <= init, pending_full <= 1. ld_en & !ld_ready → data discarded, ld_err <= 1.
- ld_ready = !pending_full (registered state only).
- Active state machine, states IDLE, RUN:
  - IDLE & pending_full: active <= pending, pending_full <= 0; if all counts zero → stay IDLE, done <= 1; else → RUN.
  - IDLE & !pending_full: hold.
  - RUN: out_valid=1. On out_valid & out_ready: granted counter −1, ptr <= (grant+1) mod NCH. If out_last also → IDLE, done <= 1.
- Arbitration: grant = first channel with nonzero count at or after ptr, cyclic. Zero channels are never granted; counters never wrap below zero.
- out_ch = grant; out_idx = count[grant] − 1; out_last = count[grant]==1 and all other counts zero.
- out_valid & !out_ready: all token outputs hold stable.
- Pending bank may be loaded at any time it is empty, including during RUN.

## Timing
- Reset values: ld_ready=1, ld_err=0, out_valid=0, out_ch=0, out_idx=0, out_last=0, done=0, busy=0; counters 0, ptr 0, state IDLE, pending_full 0.
- Reset asserted mid-crossing: all banks cleared immediately; no done pulse.
- Load-to-first-token: ld_en accepted at edge t (IDLE) → transfer at t+1 → out_valid high after edge t+1.
- Throughput: one token per cycle while out_ready=1.
- Crossing-to-crossing gap: last token accepted at edge t → IDLE, done high in cycle after t → transfer at t+1 → next out_valid after t+2 (one bubble cycle).
- out_valid, out_ch, out_idx, out_last, ld_ready, busy: combinational from registers only; no path from out_ready or ld_en to any output.
- done: registered, exactly one cycle per crossing, including zero-stub crossings.

## Structure
- Shared package ts_pkg: STUB_CNT_BITS, default NCH, per-channel count typedef.
- Sub-module ts_rr_arb: parametrised NCH round-robin priority picker (request vector + ptr → grant index, any-valid); combinational.
- Top holds pending bank, active counters, state, ptr, ld_err.

## Test plan
- Reset then load {ch0=2,ch1=0,ch2=1,ch3=3}, out_ready=1 → tokens (ch,idx): (0,1),(2,0),(3,2),(0,0),(3,1),(3,0); out_last on 6th only; done one cycle later.
- Same load, out_ready toggling 1/0 each cycle → identical token sequence, outputs stable during stalls, 12 cycles to drain.
- Load all zeros → no out_valid, single done pulse two cycles after ld_en.
- Load A={1,1,0,0} then B={0,0,0,2} during RUN → ld_ready low after B, tokens A then one bubble then B (3,1),(3,0); two done pulses.
- Second ld_en while pending full → ld_err=1 and stays 1, pending data unchanged.
- Assert rst mid-crossing (counts nonzero) → out_valid=0, busy=0, ld_ready=1 immediately, no done pulse.
